// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-side and result signals of alu_op_sequencer bundled as one interface.
// master = controller/ALU environment, slave = the sequencer.
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [FUN_WIDTH-1:0]      cmd_fun;
    logic [DATA_WIDTH-1:0]     cmd_a;
    logic [DATA_WIDTH-1:0]     cmd_b;
    logic                      alu_clk_en;
    logic                      alu_en;
    logic [FUN_WIDTH-1:0]      alu_fun;
    logic [DATA_WIDTH-1:0]     alu_a;
    logic [DATA_WIDTH-1:0]     alu_b;
    logic [2*DATA_WIDTH-1:0]   alu_out;
    logic                      alu_out_valid;
    logic                      res_valid;
    logic                      res_ready;
    logic [2*DATA_WIDTH-1:0]   res_data;
    logic                      res_err;

    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, res_ready,
        input  cmd_ready, alu_clk_en, alu_en, alu_fun, alu_a, alu_b, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, alu_out_valid, res_ready,
        output cmd_ready, alu_clk_en, alu_en, alu_fun, alu_a, alu_b, res_valid, res_data, res_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs one ALU operation per command: wake the ALU clock, strobe it, await result or timeout.
// Optional saturating op/error counters are built in when ALU_SEQ_PERF_CNT_EN is defined.
module alu_op_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FUN_WIDTH   = 4,
    parameter int WAKE_CYCLES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]       op_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0]    WAKE_LAST = 3'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_EXEC,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state_reg;
    logic [2:0]            wake_cnt_reg;
    logic [TW-1:0]         tmo_cnt_reg;
    logic [FUN_WIDTH-1:0]  fun_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [RW-1:0]         res_data_reg;
    logic                  res_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wake_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            fun_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            res_data_reg <= '0;
            res_err_reg  <= 1'b0;
`ifdef ALU_SEQ_PERF_CNT_EN
            op_cnt       <= '0;
            err_cnt      <= '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        fun_reg      <= bus.cmd_fun;
                        a_reg        <= bus.cmd_a;
                        b_reg        <= bus.cmd_b;
                        wake_cnt_reg <= '0;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= (WAKE_CYCLES == 0) ? S_EXEC : S_WAKE;
                    end
                end
                S_WAKE: begin
                    if (wake_cnt_reg == WAKE_LAST) begin
                        state_reg <= S_EXEC;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg + 3'd1;
                    end
                end
                S_EXEC: begin
                    tmo_cnt_reg <= '0;
                    state_reg   <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the terminal-count edge still counts as success.
                    if (bus.alu_out_valid) begin
                        res_data_reg <= bus.alu_out;
                        res_err_reg  <= 1'b0;
                        state_reg    <= S_HOLD;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        res_data_reg <= '0;
                        res_err_reg  <= 1'b1;
                        state_reg    <= S_HOLD;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
`ifdef ALU_SEQ_PERF_CNT_EN
                        if (!res_err_reg && op_cnt != 16'hFFFF) begin
                            op_cnt <= op_cnt + 16'd1;
                        end
                        if (res_err_reg && err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
`endif
                        res_err_reg <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so reset gates the ALU clock off at once.
    assign bus.cmd_ready  = (state_reg == S_IDLE);
    assign bus.alu_en     = (state_reg == S_EXEC);
    assign bus.alu_clk_en = (state_reg == S_WAKE) || (state_reg == S_EXEC) || (state_reg == S_WAIT);
    assign bus.res_valid  = (state_reg == S_HOLD);
    assign bus.res_data   = res_data_reg;
    assign bus.res_err    = res_err_reg;
    assign bus.alu_fun    = fun_reg;
    assign bus.alu_a      = a_reg;
    assign bus.alu_b      = b_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: three instances (WAKE_CYCLES 1, 0, 3) with a
// one-cycle registered ALU model each; ALU_SEQ_PERF_CNT_EN adds counter checks.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus1 ();
    alu_op_sequencer_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus0 ();
    alu_op_sequencer_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus3 ();

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0] op_cnt1, op_cnt0, op_cnt3;
    logic [7:0]  err_cnt1, err_cnt0, err_cnt3;
`endif

    alu_op_sequencer #(.DATA_WIDTH(8), .FUN_WIDTH(4), .WAKE_CYCLES(1), .TIMEOUT(15)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef ALU_SEQ_PERF_CNT_EN
        , .op_cnt(op_cnt1), .err_cnt(err_cnt1)
`endif
    );
    alu_op_sequencer #(.DATA_WIDTH(8), .FUN_WIDTH(4), .WAKE_CYCLES(0), .TIMEOUT(15)) u_w0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
`ifdef ALU_SEQ_PERF_CNT_EN
        , .op_cnt(op_cnt0), .err_cnt(err_cnt0)
`endif
    );
    alu_op_sequencer #(.DATA_WIDTH(8), .FUN_WIDTH(4), .WAKE_CYCLES(3), .TIMEOUT(15)) u_w3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
`ifdef ALU_SEQ_PERF_CNT_EN
        , .op_cnt(op_cnt3), .err_cnt(err_cnt3)
`endif
    );

    function automatic logic [15:0] alu_f(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        case (fun)
            4'h0:    alu_f = {8'h00, a} + {8'h00, b};
            4'h1:    alu_f = {8'h00, a} * {8'h00, b};
            default: alu_f = {8'h00, a ^ b};
        endcase
    endfunction

    // ALU models: result registered one cycle after the strobe.
    logic        resp_en;
    logic        inj_vld;
    logic [15:0] inj_data;
    logic        m1_vld, m0_vld, m3_vld;
    logic [15:0] m1_out, m0_out, m3_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_vld <= 1'b0; m0_vld <= 1'b0; m3_vld <= 1'b0;
            m1_out <= '0;   m0_out <= '0;   m3_out <= '0;
        end else begin
            m1_vld <= bus1.alu_en & resp_en;
            m0_vld <= bus0.alu_en;
            m3_vld <= bus3.alu_en;
            m1_out <= alu_f(bus1.alu_fun, bus1.alu_a, bus1.alu_b);
            m0_out <= alu_f(bus0.alu_fun, bus0.alu_a, bus0.alu_b);
            m3_out <= alu_f(bus3.alu_fun, bus3.alu_a, bus3.alu_b);
        end
    end

    assign bus1.alu_out_valid = m1_vld | inj_vld;
    assign bus1.alu_out       = inj_vld ? inj_data : m1_out;
    assign bus0.alu_out_valid = m0_vld;
    assign bus0.alu_out       = m0_out;
    assign bus3.alu_out_valid = m3_vld;
    assign bus3.alu_out       = m3_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd1(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_fun   = f;
        bus1.cmd_a     = a;
        bus1.cmd_b     = b;
    endtask

    task automatic release1(input string tag);
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        chk({tag, "_rel_valid"}, bus1.res_valid, 1'b0);
        chk({tag, "_rel_ready"}, bus1.cmd_ready, 1'b1);
        chk({tag, "_rel_err"},   bus1.res_err,   1'b0);
        $display("txn %s released", tag);
    endtask

    initial begin
        rst_n = 1'b0;
        resp_en = 1'b1; inj_vld = 1'b0; inj_data = '0;
        bus1.cmd_valid = 1'b0; bus1.cmd_fun = '0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.res_ready = 1'b0;
        bus0.cmd_valid = 1'b0; bus0.cmd_fun = '0; bus0.cmd_a = '0; bus0.cmd_b = '0; bus0.res_ready = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_fun = '0; bus3.cmd_a = '0; bus3.cmd_b = '0; bus3.res_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_cmd_ready", bus1.cmd_ready, 1'b1);
        chk("rst_clk_en",    bus1.alu_clk_en, 1'b0);
        chk("rst_alu_en",    bus1.alu_en, 1'b0);
        chk("rst_res_valid", bus1.res_valid, 1'b0);
        chk("rst_res_err",   bus1.res_err, 1'b0);
        chk("rst_res_data",  bus1.res_data, 16'h0000);
        chk("rst_alu_a",     bus1.alu_a, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Basic op: 5 + 3
        cmd1(4'h0, 8'h05, 8'h03);
        tick();
        bus1.cmd_valid = 1'b0;
        chk("basic_t0_ready",  bus1.cmd_ready, 1'b0);
        chk("basic_t0_clk_en", bus1.alu_clk_en, 1'b1);
        chk("basic_t0_alu_en", bus1.alu_en, 1'b0);
        chk("basic_alu_a",     bus1.alu_a, 8'h05);
        chk("basic_alu_b",     bus1.alu_b, 8'h03);
        tick();
        chk("basic_t1_alu_en", bus1.alu_en, 1'b1);
        tick();
        chk("basic_t2_alu_en", bus1.alu_en, 1'b0);
        chk("basic_t2_valid",  bus1.res_valid, 1'b0);
        tick();
        chk("basic_t3_valid",  bus1.res_valid, 1'b1);
        chk("basic_t3_data",   bus1.res_data, 16'h0008);
        chk("basic_t3_err",    bus1.res_err, 1'b0);
        chk("basic_t3_clk_en", bus1.alu_clk_en, 1'b0);
        release1("basic");

        // Backpressure with CMD_VALID held high throughout
        cmd1(4'h0, 8'h10, 8'h20);
        tick();
        cmd1(4'h1, 8'h07, 8'h06);
        chk("bp_alu_a_first", bus1.alu_a, 8'h10);
        repeat (3) tick();
        chk("bp_valid", bus1.res_valid, 1'b1);
        chk("bp_data",  bus1.res_data, 16'h0030);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid",  bus1.res_valid, 1'b1);
            chk("bp_hold_data",   bus1.res_data, 16'h0030);
            chk("bp_hold_ready",  bus1.cmd_ready, 1'b0);
            chk("bp_hold_clk_en", bus1.alu_clk_en, 1'b0);
            chk("bp_hold_alu_en", bus1.alu_en, 1'b0);
        end
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        chk("bp_exit_valid", bus1.res_valid, 1'b0);
        chk("bp_exit_ready", bus1.cmd_ready, 1'b1);
        chk("bp_exit_data",  bus1.res_data, 16'h0030);
        tick();
        bus1.cmd_valid = 1'b0;
        chk("bp2_accept_ready", bus1.cmd_ready, 1'b0);
        chk("bp2_alu_fun",      bus1.alu_fun, 4'h1);
        chk("bp2_alu_a",        bus1.alu_a, 8'h07);
        chk("bp2_alu_b",        bus1.alu_b, 8'h06);
        repeat (3) tick();
        chk("bp2_valid", bus1.res_valid, 1'b1);
        chk("bp2_data",  bus1.res_data, 16'h002A);
        release1("backpressure");

        // Timeout: no ALU response
        resp_en = 1'b0;
        cmd1(4'h2, 8'h01, 8'h01);
        tick();
        bus1.cmd_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_wait_valid", bus1.res_valid, 1'b0);
        end
        tick();
        chk("tmo_valid",  bus1.res_valid, 1'b1);
        chk("tmo_err",    bus1.res_err, 1'b1);
        chk("tmo_data",   bus1.res_data, 16'h0000);
        chk("tmo_clk_en", bus1.alu_clk_en, 1'b0);
        inj_data = 16'h1234;
        inj_vld  = 1'b1;
        tick();
        inj_vld  = 1'b0;
        chk("tmo_hold_spur_data",  bus1.res_data, 16'h0000);
        chk("tmo_hold_spur_err",   bus1.res_err, 1'b1);
        chk("tmo_hold_spur_valid", bus1.res_valid, 1'b1);
        release1("timeout");
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        chk("idle_spur_ready",  bus1.cmd_ready, 1'b1);
        chk("idle_spur_valid",  bus1.res_valid, 1'b0);
        chk("idle_spur_clk_en", bus1.alu_clk_en, 1'b0);

        // Valid arriving on the terminal-count edge wins
        cmd1(4'h3, 8'h02, 8'h02);
        tick();
        bus1.cmd_valid = 1'b0;
        tick();
        tick();
        repeat (14) tick();
        chk("term_still_wait", bus1.res_valid, 1'b0);
        inj_data = 16'hBEEF;
        inj_vld  = 1'b1;
        tick();
        inj_vld  = 1'b0;
        chk("term_valid", bus1.res_valid, 1'b1);
        chk("term_err",   bus1.res_err, 1'b0);
        chk("term_data",  bus1.res_data, 16'hBEEF);
        release1("terminal");
        resp_en = 1'b1;
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("perf_op_cnt",  op_cnt1, 16'd4);
        chk("perf_err_cnt", err_cnt1, 8'd1);
`endif

        // WAKE_CYCLES = 0: strobe together with clock enable
        bus0.cmd_valid = 1'b1; bus0.cmd_fun = 4'h1; bus0.cmd_a = 8'h03; bus0.cmd_b = 8'h04;
        tick();
        bus0.cmd_valid = 1'b0;
        chk("w0_clk_en", bus0.alu_clk_en, 1'b1);
        chk("w0_alu_en", bus0.alu_en, 1'b1);
        tick();
        chk("w0_alu_en_off", bus0.alu_en, 1'b0);
        chk("w0_wait_clk_en", bus0.alu_clk_en, 1'b1);
        tick();
        chk("w0_valid", bus0.res_valid, 1'b1);
        chk("w0_data",  bus0.res_data, 16'h000C);
        bus0.res_ready = 1'b1;
        tick();
        bus0.res_ready = 1'b0;
        chk("w0_rel_valid", bus0.res_valid, 1'b0);
        $display("txn wake0 released");

        // WAKE_CYCLES = 3: strobe three cycles after clock enable
        bus3.cmd_valid = 1'b1; bus3.cmd_fun = 4'h0; bus3.cmd_a = 8'h80; bus3.cmd_b = 8'h80;
        tick();
        bus3.cmd_valid = 1'b0;
        chk("w3_clk_en", bus3.alu_clk_en, 1'b1);
        chk("w3_en_c0",  bus3.alu_en, 1'b0);
        chk("w3_a_c0",   bus3.alu_a, 8'h80);
        tick();
        chk("w3_en_c1", bus3.alu_en, 1'b0);
        tick();
        chk("w3_en_c2", bus3.alu_en, 1'b0);
        tick();
        chk("w3_en_c3", bus3.alu_en, 1'b1);
        chk("w3_a_c3",  bus3.alu_a, 8'h80);
        chk("w3_b_c3",  bus3.alu_b, 8'h80);
        chk("w3_fun",   bus3.alu_fun, 4'h0);
        tick();
        chk("w3_en_c4", bus3.alu_en, 1'b0);
        tick();
        chk("w3_valid", bus3.res_valid, 1'b1);
        chk("w3_data",  bus3.res_data, 16'h0100);
        bus3.res_ready = 1'b1;
        tick();
        bus3.res_ready = 1'b0;
        chk("w3_rel_valid", bus3.res_valid, 1'b0);
        $display("txn wake3 released");

        // Asynchronous reset in the middle of WAIT
        resp_en = 1'b0;
        cmd1(4'h0, 8'h09, 8'h01);
        tick();
        bus1.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("arst_pre_clk_en", bus1.alu_clk_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk_en", bus1.alu_clk_en, 1'b0);
        chk("arst_alu_en", bus1.alu_en, 1'b0);
        chk("arst_valid",  bus1.res_valid, 1'b0);
        chk("arst_ready",  bus1.cmd_ready, 1'b1);
        chk("arst_alu_a",  bus1.alu_a, 8'h00);
        #1 rst_n = 1'b1;
        resp_en = 1'b1;
        tick();
        chk("arst_post_ready", bus1.cmd_ready, 1'b1);
        cmd1(4'h0, 8'h09, 8'h01);
        tick();
        bus1.cmd_valid = 1'b0;
        repeat (3) tick();
        chk("arst_op_valid", bus1.res_valid, 1'b1);
        chk("arst_op_data",  bus1.res_data, 16'h000A);
        chk("arst_op_err",   bus1.res_err, 1'b0);
        release1("post_reset");
        chk("operand_hold_a", bus1.alu_a, 8'h09);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("perf_op_cnt_after_rst",  op_cnt1, 16'd1);
        chk("perf_err_cnt_after_rst", err_cnt1, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences single ALU operations for the system controller.
- Accepts one command (function code plus two operands) over a valid/ready handshake. Wakes the ALU through its clock-gate enable, pulses the ALU enable for one cycle, and waits for the ALU result-valid.
- Returns the result, or a timeout error, over a second valid/ready handshake.
- Keeps the ALU clock gated off whenever no operation is in flight.

Parameters:
- DATA_WIDTH, 8: operand width; the result is 2*DATA_WIDTH.
- FUN_WIDTH, 4: ALU function code width.
- WAKE_CYCLES, 1: cycles ALU_CLK_EN is high before ALU_EN. Legal range 0..7.
- TIMEOUT, 15: maximum WAIT cycles for ALU_OUT_VALID. Must be >= 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_FUN  in  FUN_WIDTH  ALU function code.
- CMD_A  in  DATA_WIDTH  operand A.
- CMD_B  in  DATA_WIDTH  operand B.
- ALU_CLK_EN  out  1  enable to the ALU clock gate.
- ALU_EN  out  1  one-cycle ALU operation strobe.
- ALU_FUN  out  FUN_WIDTH  latched function code.
- ALU_A  out  DATA_WIDTH  latched operand A.
- ALU_B  out  DATA_WIDTH  latched operand B.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- ALU_OUT_VALID  in  1  ALU result valid.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer takes the result.
- RES_DATA  out  2*DATA_WIDTH  result.
- RES_ERR  out  1  1 = timeout; RES_DATA is 0.

Behaviour:
- Reset (RST low, asynchronous):
  - State returns to IDLE; all counters clear.
  - ALU_CLK_EN, ALU_EN, RES_VALID, RES_ERR = 0.
  - RES_DATA, ALU_FUN, ALU_A, ALU_B = 0.
  - An in-flight operation is discarded with no result. ALU_CLK_EN drops immediately, not at the next edge.
- Output decoding from state:
  - CMD_READY = (state==IDLE).
  - ALU_EN = (state==EXEC).
  - ALU_CLK_EN = state in {WAKE, EXEC, WAIT}.
- States: IDLE, WAKE, EXEC, WAIT, HOLD.
- IDLE:
  - On CMD_VALID&CMD_READY at edge T0: latch CMD_FUN/A/B into ALU_FUN/A/B.
  - Go to WAKE, or directly to EXEC if WAKE_CYCLES=0.
  - ALU_FUN/A/B hold until the next accept.
- WAKE: stay exactly WAKE_CYCLES cycles (3-bit counter), then go to EXEC.
- EXEC: exactly one cycle, then go to WAIT.
- WAIT:
  - The timeout counter clears on entry and increments every WAIT cycle.
  - ALU_OUT_VALID=1 at an edge: RES_DATA<=ALU_OUT, RES_ERR<=0, RES_VALID<=1, go to HOLD.
  - Counter reaches TIMEOUT with no valid: RES_DATA<=0, RES_ERR<=1, RES_VALID<=1, go to HOLD.
  - If valid and the terminal count coincide at the same edge, valid wins (RES_ERR=0).
- HOLD:
  - RES_VALID, RES_DATA and RES_ERR stay stable until RES_READY=1 at an edge.
  - On that edge: RES_VALID<=0, RES_ERR<=0, go to IDLE.
  - RES_DATA keeps its last value.
- ALU_OUT_VALID is ignored in every state except WAIT. This covers late results after a timeout and spurious valids in IDLE/EXEC/HOLD.
- Latency, with WAKE_CYCLES=1 and a 1-cycle registered ALU:
  - ALU_EN is high in the cycle after T1.
  - RES_VALID is high after T3.
  - In general, accept-to-RES_VALID = WAKE_CYCLES + 1 + ALU latency.
- Throughput:
  - CMD_READY is low from accept until the HOLD exit.
  - The earliest next accept is the edge after the HOLD->IDLE edge.
  - No command is dropped: CMD_VALID may stay high; it is sampled only in IDLE.
- CMD_FUN is passed through unchanged; no function decoding is done here.

Optional Feature:
- Macro: ALU_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output OP_CNT [15:0] and output ERR_CNT [7:0].
  - OP_CNT increments on each HOLD exit with RES_ERR=0.
  - ERR_CNT increments on each HOLD exit with RES_ERR=1.
  - Both saturate (0xFFFF / 0xFF) and are reset to 0 by RST.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic op: CMD_FUN=4'h0, A=8'h05, B=8'h03; ALU model returns 16'h0008 one cycle after ALU_EN -> ALU_EN high exactly 1 cycle after T1; RES_VALID after T3 with RES_DATA=16'h0008, RES_ERR=0; RES_READY=1 -> IDLE, CMD_READY=1 after T4.
- Backpressure: RES_READY low for 10 cycles with CMD_VALID held high -> RES_VALID/RES_DATA stable, CMD_READY=0, ALU_CLK_EN=0, no second ALU_EN; after RES_READY, the second command is accepted at the next edge.
- Timeout: ALU never asserts valid, TIMEOUT=15 -> RES_VALID after 15 WAIT cycles with RES_ERR=1, RES_DATA=0; ALU_OUT_VALID pulsed during HOLD and IDLE has no effect.
- WAKE_CYCLES=0 and WAKE_CYCLES=3 -> ALU_EN rises 0 and 3 cycles after ALU_CLK_EN respectively; ALU_FUN/A/B stable throughout.
- Reset mid-WAIT: RST low -> ALU_CLK_EN, ALU_EN, RES_VALID=0 without a clock edge; after release, CMD_READY=1 and the next command completes normally.
- With ALU_SEQ_PERF_CNT_EN: 3 good ops + 1 timeout -> OP_CNT=3, ERR_CNT=1; forced OP_CNT=16'hFFFF plus one good op -> stays 16'hFFFF.
